// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_ERROR
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  localparam int unsigned JT_MSB  = 25;
  localparam int unsigned JT_LSB  = 0;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch, or sequential pc+4.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_imm_ext;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_br_tgt;
  logic        w_unused_opcode;

  assign w_pc4      = pc + PC_INC;
  assign w_jump_tgt = {w_pc4[31:28], instr[JT_MSB:JT_LSB], 2'b00};
  assign w_imm_ext  = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
  assign w_br_tgt   = w_pc4 + (w_imm_ext << 2);

  // Opcode bits play no part in target formation; the decoder already resolved them.
  assign w_unused_opcode = ^instr[31:26];

  always_comb begin
    next_pc = w_pc4;
    if (jump) begin
      next_pc = w_jump_tgt;
    end else if (branch && zero) begin
      next_pc = w_br_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/response, decode valid/ready hand-off.
// Optional WAIT timeout with sticky error enabled by FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("fetch_unit: TIMEOUT_CYCLES must be >= 1");
  end

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic [31:0] w_next_pc;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_wait_cnt;
  logic          r_fetch_err;
`endif

  next_pc_calc u_next_pc_calc (
    .pc      (r_pc),
    .instr   (r_instr),
    .branch  (branch),
    .jump    (jump),
    .zero    (zero),
    .next_pc (w_next_pc)
  );

  // Outputs are registered: each flag is set on the edge that enters its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_fetch_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
        end
        ST_REQ: begin
          r_state    <= ST_WAIT;
          r_imem_req <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (imem_valid) begin
            r_state       <= ST_ISSUE;
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= ST_ERROR;
            r_fetch_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
`endif
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            r_state       <= ST_REQ;
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
          end
        end
        ST_ERROR: begin
          r_state <= ST_ERROR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
